// File: rtl/fir_mac_sched_if.sv
// fir_mac_sched_if: sample in/out handshakes and coefficient write port of the FIR scheduler.
interface fir_mac_sched_if #(
  parameter int WIDTH_DATA  = 16,
  parameter int WIDTH_COEFF = 16,
  parameter int NO_TAPS     = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic                          in_ch;
  logic [WIDTH_DATA-1:0]         in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_ch;
  logic [WIDTH_DATA-1:0]         out_data;
  logic                          coeff_we;
  logic [$clog2(NO_TAPS):0]      coeff_addr;
  logic [WIDTH_COEFF-1:0]        coeff_data;
  logic                          coeff_err;
  modport master (
    output in_valid, in_ch, in_data, out_ready, coeff_we, coeff_addr, coeff_data,
    input  in_ready, out_valid, out_ch, out_data, coeff_err
  );
  modport slave (
    input  in_valid, in_ch, in_data, out_ready, coeff_we, coeff_addr, coeff_data,
    output in_ready, out_valid, out_ch, out_data, coeff_err
  );
endinterface

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: serial stereo FIR, one shared MAC over NO_TAPS cycles per sample.
// Define FIR_MAC_SCHED_SAT_EN to clamp the scaled result instead of wrapping it.
module fir_mac_sched #(
  parameter int WIDTH_DATA  = 16,
  parameter int WIDTH_COEFF = 16,
  parameter int NO_TAPS     = 32,
  parameter int WIDTH_SUM   = 40
) (
  input logic            clk_i,
  input logic            rst_ni,
  fir_mac_sched_if.slave bus
);
  localparam int AW = $clog2(NO_TAPS);
  localparam logic signed [WIDTH_COEFF-1:0] H_ONE = {1'b0, {(WIDTH_COEFF-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;
  state_t state;
  logic [AW-1:0] wp [2];
  logic [AW-1:0] k;
  logic ch;
  logic signed [WIDTH_DATA-1:0] x [2][NO_TAPS];
  logic signed [WIDTH_COEFF-1:0] h [NO_TAPS];
  logic signed [WIDTH_SUM-1:0] acc;
  logic [AW-1:0] wp_in, tap_idx;
  logic signed [WIDTH_DATA+WIDTH_COEFF-1:0] prod;
  logic [WIDTH_DATA-1:0] scaled;
  logic coeff_ok;
  assign wp_in    = wp[bus.in_ch] + AW'(1);
  assign tap_idx  = wp[ch] - k;
  assign prod     = x[ch][tap_idx] * h[k];
  assign coeff_ok = bus.coeff_we && state == IDLE && !bus.coeff_addr[AW];
`ifdef FIR_MAC_SCHED_SAT_EN
  localparam logic signed [WIDTH_SUM-1:0] MAX_S = {{(WIDTH_SUM-WIDTH_DATA+1){1'b0}}, {(WIDTH_DATA-1){1'b1}}};
  localparam logic signed [WIDTH_SUM-1:0] MIN_S = ~MAX_S;
  logic signed [WIDTH_SUM-1:0] sh;
  assign sh     = acc >>> (WIDTH_COEFF-1);
  assign scaled = sh > MAX_S ? MAX_S[WIDTH_DATA-1:0] : sh < MIN_S ? MIN_S[WIDTH_DATA-1:0] : sh[WIDTH_DATA-1:0];
`else
  // Floor shift followed by truncation is just a bit slice of the accumulator.
  assign scaled = acc[WIDTH_COEFF-1 +: WIDTH_DATA];
`endif
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_ch    <= 1'b0;
      bus.out_data  <= '0;
      bus.coeff_err <= 1'b0;
      ch            <= 1'b0;
      k             <= '0;
      acc           <= '0;
      for (int c = 0; c < 2; c++) begin
        wp[c] <= '0;
        for (int i = 0; i < NO_TAPS; i++) x[c][i] <= '0;
      end
      for (int i = 0; i < NO_TAPS; i++) h[i] <= (i == 0) ? H_ONE : '0;
    end else begin
      bus.coeff_err <= bus.coeff_we && !coeff_ok;
      if (coeff_ok) h[bus.coeff_addr[AW-1:0]] <= bus.coeff_data;
      case (state)
        IDLE: if (bus.in_valid) begin
          wp[bus.in_ch]        <= wp_in;
          x[bus.in_ch][wp_in]  <= bus.in_data;
          ch                   <= bus.in_ch;
          acc                  <= '0;
          k                    <= '0;
          bus.in_ready         <= 1'b0;
          state                <= MAC;
        end
        MAC: begin
          acc <= acc + WIDTH_SUM'(prod);
          k   <= k + AW'(1);
          if (k == AW'(NO_TAPS-1)) state <= SCALE;
        end
        SCALE: begin
          bus.out_data  <= scaled;
          bus.out_ch    <= ch;
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end
        OUT: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
